apb_mem_slave: RTL
==================

Name: apb_mem_slave

Overview:
- Parametrised APB4 slave memory: the memory target that APB bench traffic writes into and reads back from.
- Generalises the fixed 16-bit-address / 32-bit-data memory to configurable address width, data width and depth.
- Adds features the current target lacks: programmable wait states via PReady, byte strobes, read-back, and error response via PSlvErr.
- Sits directly on the APB bus, replacing the fixed memory instance under top.

Parameters:
- ADDR_W, 16, PAddr width in bits.
- DATA_W, 32, PWData/PRData width; legal values 8, 16, 32 or 64.
- DEPTH, 1024, number of DATA_W-wide words; legal range 2 to 2**(ADDR_W-log2(DATA_W/8)).
- WAIT_STATES, 0, extra access-phase cycles before PReady; legal range 0 to 15.

Ports:
- clk  in  1  clock, all logic on rising edge.
- Rst  in  1  synchronous active-low reset.
- PSel  in  1  slave select.
- PEnable  in  1  access phase indicator.
- PWrite  in  1  1 = write, 0 = read.
- PAddr  in  ADDR_W  byte address.
- PWData  in  DATA_W  write data.
- PStrb  in  DATA_W/8  byte write enables.
- PRData  out  DATA_W  read data; valid only while PReady=1 on a read.
- PReady  out  1  transfer complete.
- PSlvErr  out  1  error flag; valid only while PReady=1.

Behaviour:
- Reset (Rst=0 at a clk edge): PReady=0, PSlvErr=0, PRData=0, FSM=IDLE, wait counter=0. Memory contents are not reset.
- FSM states:
  - IDLE: on PSel=1 & PEnable=0 (setup phase), latch PAddr, PWrite, PWData, PStrb; load counter=WAIT_STATES; go to ACCESS. If WAIT_STATES=0, PReady=1 in the same edge, so completion falls in the first access cycle.
  - ACCESS:
    - If PSel=1, PEnable=1 and counter>1: decrement the counter.
    - When the counter reaches 1: set PReady on that edge.
    - In the cycle where PSel=1, PEnable=1 and PReady=1, the transfer completes. On the next edge: commit the write if legal, clear PReady/PSlvErr, set PRData=0, return to IDLE.
  - Access phase length is WAIT_STATES+1 cycles.
- Word index = PAddr >> log2(DATA_W/8).
- Error condition: index >= DEPTH, or PAddr not aligned to DATA_W/8. PSlvErr is set together with PReady.
- On error:
  - A write does not modify memory.
  - PRData=0.
- Read: PRData is loaded from memory on the same edge that sets PReady. It equals the memory contents at latch time.
- Write: only byte lanes with PStrb[i]=1 are updated; PStrb=0 is a legal no-op. The write is committed exactly once, on the edge ending the completing cycle.
- Abort: PSel=0 while in ACCESS → next edge goes to IDLE, clears PReady/PSlvErr, sets PRData=0; no write occurs.
- PEnable=1 seen in IDLE without a preceding setup phase: ignored, PReady stays 0.
- Back-to-back transfers: a new setup phase in the cycle after completion is accepted normally. Minimum transfer is 2 cycles (setup plus one access cycle).
- Reset mid-transfer: takes priority over all other activity; the pending write is dropped and the memory is left untouched.
- Read-after-write to the same address in consecutive transfers returns the newly written data.

Decomposition:
- Package apb_mem_pkg holds:
  - state enum typedef {IDLE, ACCESS};
  - localparam helper function clog2-based byte-offset width;
  - the error-check function (alignment plus range).
- One sub-module, apb_mem_array: single-port byte-writable storage (DATA_W, DEPTH). Ports: clk, we, idx, strb, wdata, rdata; rdata is combinational.
- The FSM, wait counter and APB outputs stay in apb_mem_slave.

Test Plan:
- Defaults, after reset, write PAddr=16'h50, PWData=32'h50, PStrb=4'hF; then read 16'h50 → PReady=1 in the first access cycle of each transfer, PRData=32'h50, PSlvErr=0.
- WAIT_STATES=2, read 16'h50 → PReady low for 2 access cycles, high on the 3rd; PRData=32'h50.
- Write 32'hAABBCCDD to 16'h10, then write 32'h11223344 with PStrb=4'b0101, read back → PRData=32'hAA22CC44.
- DEPTH=1024, write to PAddr=16'h1000 (index 1024), then read 16'h1000 → PSlvErr=1 with PReady, PRData=0 on both; memory unchanged.
- Misaligned write to 16'h52 → PSlvErr=1; word at 16'h50 unchanged.
- WAIT_STATES=3, assert Rst=0 during the 2nd access cycle of a write to 16'h20 → PReady=0, PRData=0 on the next edge; a later read of 16'h20 returns the old value. Separately, drop PSel mid-access → no write, FSM back to IDLE.

Source files
------------

// File: rtl/apb_mem_pkg.sv
// Shared types and address-decode helpers for the APB memory slave.
// Pulled into apb_mem_slave so the decode rules are written down in one place.
package apb_mem_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    function automatic int byte_off_w(input int data_w);
        return $clog2(data_w / 8);
    endfunction

    // Misaligned byte address or word index past the end of the memory.
    function automatic logic addr_err(
        input logic [63:0] addr,
        input int          off_w,
        input longint      depth
    );
        logic [63:0] mask;
        mask = (64'd1 << off_w) - 64'd1;
        return ((addr & mask) != 64'd0) || ((addr >> off_w) >= 64'(depth));
    endfunction

endpackage

// File: rtl/apb_mem_array.sv
// Single-port word storage with per-byte write enables and combinational read.
// Written only on the edge that ends a completing APB write.
module apb_mem_array #(
    parameter  int DATA_W = 32,
    parameter  int DEPTH  = 1024,
    localparam int IDX_W  = $clog2(DEPTH),
    localparam int STRB_W = DATA_W / 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic [IDX_W-1:0]  idx,
    input  logic [STRB_W-1:0] strb,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] bit_mask;

    genvar gi;
    generate
        for (gi = 0; gi < STRB_W; gi++) begin : g_lane
            assign bit_mask[gi*8 +: 8] = {8{strb[gi]}};
        end
    endgenerate

    // Read-modify-write of the whole word keeps a single write port.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[idx] <= (mem[idx] & ~bit_mask) | (wdata & bit_mask);
        end
    end

    assign rdata = mem[idx];

endmodule

// File: rtl/apb_mem_slave.sv
// APB4 memory target with programmable wait states, byte strobes and error response.
// Outputs are registered; completion is seen in access cycle WAIT_STATES+1.
module apb_mem_slave
    import apb_mem_pkg::*;
#(
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 32,
    parameter int DEPTH       = 1024,
    parameter int WAIT_STATES = 0
) (
    input  logic                clk,
    input  logic                Rst,
    input  logic                PSel,
    input  logic                PEnable,
    input  logic                PWrite,
    input  logic [ADDR_W-1:0]   PAddr,
    input  logic [DATA_W-1:0]   PWData,
    input  logic [DATA_W/8-1:0] PStrb,
    output logic [DATA_W-1:0]   PRData,
    output logic                PReady,
    output logic                PSlvErr
);

    localparam int OFF_W  = byte_off_w(DATA_W);
    localparam int IDX_W  = $clog2(DEPTH);
    localparam int STRB_W = DATA_W / 8;

    state_t              state_reg;
    logic [3:0]          cnt_reg;
    logic [IDX_W-1:0]    idx_reg;
    logic                err_reg;
    logic                write_reg;
    logic [DATA_W-1:0]   wdata_reg;
    logic [STRB_W-1:0]   strb_reg;
    logic                ready_reg;
    logic                slverr_reg;
    logic [DATA_W-1:0]   rdata_reg;

    logic                setup_err;
    logic [IDX_W-1:0]    setup_idx;
    logic [IDX_W-1:0]    mem_idx;
    logic                mem_we;
    logic [DATA_W-1:0]   mem_rdata;

    assign setup_err = addr_err(64'(PAddr), OFF_W, DEPTH);
    assign setup_idx = IDX_W'(PAddr >> OFF_W);

    // With zero wait states the read happens on the setup edge, before idx_reg is loaded.
    assign mem_idx = (state_reg == IDLE) ? setup_idx : idx_reg;
    assign mem_we  = Rst && (state_reg == ACCESS) && PSel && PEnable && ready_reg
                     && write_reg && !err_reg;

    apb_mem_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_array (
        .clk   (clk),
        .we    (mem_we),
        .idx   (mem_idx),
        .strb  (strb_reg),
        .wdata (wdata_reg),
        .rdata (mem_rdata)
    );

    always_ff @(posedge clk) begin
        if (!Rst) begin
            state_reg  <= IDLE;
            cnt_reg    <= '0;
            ready_reg  <= 1'b0;
            slverr_reg <= 1'b0;
            rdata_reg  <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (PSel && !PEnable) begin
                        idx_reg   <= setup_idx;
                        err_reg   <= setup_err;
                        write_reg <= PWrite;
                        wdata_reg <= PWData;
                        strb_reg  <= PStrb;
                        cnt_reg   <= 4'(WAIT_STATES);
                        state_reg <= ACCESS;
                        if (WAIT_STATES == 0) begin
                            ready_reg  <= 1'b1;
                            slverr_reg <= setup_err;
                            rdata_reg  <= (!PWrite && !setup_err) ? mem_rdata : '0;
                        end
                    end
                end
                ACCESS: begin
                    if (!PSel || (PEnable && ready_reg)) begin
                        state_reg  <= IDLE;
                        cnt_reg    <= '0;
                        ready_reg  <= 1'b0;
                        slverr_reg <= 1'b0;
                        rdata_reg  <= '0;
                    end else if (PEnable && cnt_reg > 4'd1) begin
                        cnt_reg <= cnt_reg - 4'd1;
                    end else if (PEnable && cnt_reg == 4'd1) begin
                        cnt_reg    <= '0;
                        ready_reg  <= 1'b1;
                        slverr_reg <= err_reg;
                        rdata_reg  <= (!write_reg && !err_reg) ? mem_rdata : '0;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign PReady  = ready_reg;
    assign PSlvErr = slverr_reg;
    assign PRData  = rdata_reg;

endmodule
